// File: rtl/fp32_add_stream_if.sv
// fp32_add_stream_if: operand, adder-side and result ports of the FP32 add stream wrapper.
interface fp32_add_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    // Producer/consumer/adder side (environment)
    modport master (
        output in_valid, in_a, in_b, add_result, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_data
    );

    // Wrapper side
    modport slave (
        input  in_valid, in_a, in_b, add_result, out_ready,
        output in_ready, add_a, add_b, out_valid, out_data
    );
endinterface

// File: rtl/fp32_add_stream.sv
// fp32_add_stream: issue/collect wrapper around a fixed-latency FP32 pipelined adder.
// Credit accounting (FIFO count + in-flight ops) guarantees every adder result is captured.
// Optional feature macro: ADD_STREAM_SPECIAL_EN (NaN/Inf results produced by the wrapper).
// All state updates on the falling edge of clk_n; ADD_LAT must equal the adder stage count.
module fp32_add_stream #(
    parameter int unsigned ADD_LAT = 6,
    parameter int unsigned DEPTH   = 8
) (
    input  logic             clk_n,
    input  logic             rst_n,
    fp32_add_stream_if.slave bus,
    output logic             busy
);
    localparam int unsigned DW = 32;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned IW = $clog2(ADD_LAT + 1);
    localparam int unsigned TW = ((CW > IW) ? CW : IW) + 1;

    logic [ADD_LAT-1:0] vpipe;
    logic [DW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [IW-1:0]      inflight_c;
    logic [TW-1:0]      total_c;
    logic               fire_c;
    logic               cap_c;
    logic               pop_c;
    logic [DW-1:0]      cap_data_c;

    // Credit total from registered state only, so in_ready never depends on in_valid
    always_comb begin
        inflight_c = '0;
        for (int unsigned i = 0; i < ADD_LAT; i++) begin
            inflight_c = inflight_c + IW'(vpipe[i]);
        end
        total_c = TW'(count) + TW'(inflight_c);
    end

    assign bus.in_ready  = (total_c < TW'(DEPTH));
    assign fire_c        = bus.in_valid & bus.in_ready;
    assign bus.add_a     = fire_c ? bus.in_a : '0;
    assign bus.add_b     = fire_c ? bus.in_b : '0;
    assign cap_c         = vpipe[ADD_LAT-1];
    assign bus.out_valid = (count != '0);
    assign pop_c         = bus.out_valid & bus.out_ready;
    assign bus.out_data  = mem[rd_ptr];
    assign busy          = (vpipe != '0) | (count != '0);

    // In-flight tracking: one bit per adder stage
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[ADD_LAT-2:0], fire_c};
        end
    end

`ifdef ADD_STREAM_SPECIAL_EN
    logic [ADD_LAT-1:0] spec_pipe;
    logic [DW-1:0]      spec_val [ADD_LAT];
    logic               spec_c;
    logic [DW-1:0]      spec_val_c;
    logic               a_nan_c, b_nan_c, a_inf_c, b_inf_c;

    // Operand classification: NaN or opposite infinities -> canonical qNaN, else the Inf operand
    always_comb begin
        a_nan_c    = (&bus.in_a[30:23]) & (|bus.in_a[22:0]);
        b_nan_c    = (&bus.in_b[30:23]) & (|bus.in_b[22:0]);
        a_inf_c    = (&bus.in_a[30:23]) & ~(|bus.in_a[22:0]);
        b_inf_c    = (&bus.in_b[30:23]) & ~(|bus.in_b[22:0]);
        spec_c     = a_nan_c | b_nan_c | a_inf_c | b_inf_c;
        spec_val_c = a_inf_c ? bus.in_a : bus.in_b;
        if (a_nan_c || b_nan_c || (a_inf_c && b_inf_c && (bus.in_a[31] != bus.in_b[31]))) begin
            spec_val_c = 32'h7FC0_0000;
        end
    end

    // Side pipeline carrying the override flag and value, aligned with vpipe
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            spec_pipe <= '0;
            for (int unsigned i = 0; i < ADD_LAT; i++) begin
                spec_val[i] <= '0;
            end
        end else begin
            spec_pipe   <= {spec_pipe[ADD_LAT-2:0], fire_c & spec_c};
            spec_val[0] <= spec_val_c;
            for (int unsigned i = 1; i < ADD_LAT; i++) begin
                spec_val[i] <= spec_val[i-1];
            end
        end
    end

    assign cap_data_c = spec_pipe[ADD_LAT-1] ? spec_val[ADD_LAT-1] : bus.add_result;
`else
    assign cap_data_c = bus.add_result;
`endif

    // Output FIFO: capture at adder exit, pop on consumer handshake
    always_ff @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (cap_c) begin
                mem[wr_ptr] <= cap_data_c;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (cap_c && !pop_c) begin
                count <= count + CW'(1);
            end else if (pop_c && !cap_c) begin
                count <= count - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_fp32_add_stream.sv
// tb_fp32_add_stream: scoreboard bench for fp32_add_stream with a behavioural 6-stage FP32 adder.
// Honours ADD_STREAM_SPECIAL_EN for the NaN/Inf cases.
module tb_fp32_add_stream;
    localparam int unsigned ADD_LAT = 6;
    localparam int unsigned DEPTH   = 8;

    logic clk_n;
    logic rst_n;
    logic busy;
    fp32_add_stream_if bus ();

    fp32_add_stream #(.ADD_LAT(ADD_LAT), .DEPTH(DEPTH)) dut (
        .clk_n (clk_n),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    int          n_cmp;
    int          n_err;
    int          n_fires;
    int          n_pops;
    logic [31:0] exp_val;
    logic [31:0] last_out;
    logic [31:0] sb_q[$];
    logic [31:0] adder_stage [ADD_LAT];

    initial clk_n = 1'b1;
    always #5 clk_n = ~clk_n;

    // fp32 -> fp64 bit conversion for normals and zero
    function automatic logic [63:0] f2d(input logic [31:0] f);
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        return {f[31], 11'(32'(f[30:23]) + 32'd896), f[22:0], 29'd0};
    endfunction

    // fp64 -> fp32 with round-to-nearest-even, normal range only
    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [31:0] r;
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52];
        r = {d[63], 8'(e - 11'd896), d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) r = r + 32'd1;
        return r;
    endfunction

    function automatic logic [31:0] fp_add_model(input logic [31:0] a, input logic [31:0] b);
        real s;
        s = $bitstoreal(f2d(a)) + $bitstoreal(f2d(b));
        return d2f($realtobits(s));
    endfunction

    function automatic logic [31:0] rand_norm();
        return {1'($urandom), 8'($urandom_range(140, 110)), 23'($urandom)};
    endfunction

    // External adder: samples at edge k, Result valid from edge k+5
    always @(negedge clk_n or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ADD_LAT; i++) adder_stage[i] <= '0;
        end else begin
            adder_stage[0] <= fp_add_model(bus.add_a, bus.add_b);
            for (int i = 1; i < ADD_LAT; i++) adder_stage[i] <= adder_stage[i-1];
        end
    end
    assign bus.add_result = adder_stage[ADD_LAT-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: called at the rising edge, observes handshakes that occur at the next falling edge
    task automatic step();
        logic fire;
        logic pop;
        fire = bus.in_valid & bus.in_ready;
        pop  = bus.out_valid & bus.out_ready;
        if (pop) begin
            n_pops++;
            last_out = bus.out_data;
            if (sb_q.size() == 0) check("sb_unexpected", 32'(sb_q.size()), 32'd1);
            else check("sb_data", bus.out_data, sb_q.pop_front());
        end
        if (fire) begin
            n_fires++;
            sb_q.push_back(exp_val);
        end
        @(negedge clk_n);
        @(posedge clk_n);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        exp_val      = e;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((sb_q.size() != 0 || busy) && guard < 60) begin
            step();
            guard++;
        end
        check({tag, "_timeout"}, 32'(guard >= 60), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int f0;
        int p0;
        int lat;
        logic [31:0] a;
        logic [31:0] b;
        n_cmp = 0; n_err = 0; n_fires = 0; n_pops = 0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        exp_val = '0; last_out = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk_n);
        rst_n = 1'b1;

        // Reset state
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_a", bus.add_a, 32'h0);
        check("rst_add_b", bus.add_b, 32'h0);

        // Single op: 1.0 + 2.0, minimum latency
        bus.out_ready = 1'b1;
        issue(32'h3F80_0000, 32'h4000_0000, fp_add_model(32'h3F80_0000, 32'h4000_0000));
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("single_latency", 32'(lat), 32'd6);
        step();
        check("single_data", last_out, 32'h4040_0000);
        check("single_busy", 32'(busy), 32'd0);

        // Back-pressure: credit stops issue at exactly DEPTH
        bus.out_ready = 1'b0;
        f0 = n_fires;
        for (int i = 0; i < 20; i++) begin
            a = rand_norm(); b = rand_norm();
            bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
            exp_val = fp_add_model(a, b);
            step();
        end
        bus.in_valid = 1'b0;
        check("bp_fires", 32'(n_fires - f0), 32'(DEPTH));
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        p0 = n_pops;
        drain("bp_drain");
        check("bp_pops", 32'(n_pops - p0), 32'(DEPTH));

        // FIFO at DEPTH-1, capture and pop on the same edge
        bus.out_ready = 1'b0;
        p0 = n_pops;
        for (int i = 0; i < DEPTH - 1; i++) begin
            a = rand_norm(); b = rand_norm();
            issue(a, b, fp_add_model(a, b));
        end
        repeat (7) step();
        check("full_pre_ready", 32'(bus.in_ready), 32'd1);
        a = rand_norm(); b = rand_norm();
        issue(a, b, fp_add_model(a, b));
        repeat (5) step();
        check("full_no_credit", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("full_credit_back", 32'(bus.in_ready), 32'd1);
        step();
        check("full_still_valid", 32'(bus.out_valid), 32'd1);
        drain("full_drain");
        check("full_pops", 32'(n_pops - p0), 32'(DEPTH));

        // Reset mid-stream: 2 in FIFO, 3 in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = rand_norm(); b = rand_norm();
            issue(a, b, fp_add_model(a, b));
        end
        repeat (7) step();
        for (int i = 0; i < 3; i++) begin
            a = rand_norm(); b = rand_norm();
            issue(a, b, fp_add_model(a, b));
        end
        check("mid_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_out_data", bus.out_data, 32'h0);
        check("mid_in_ready", 32'(bus.in_ready), 32'd1);
        sb_q.delete();
        @(posedge clk_n);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        p0 = n_pops;
        repeat (10) step();
        check("mid_no_stale", 32'(n_pops - p0), 32'd0);

        // Streaming: 100 back-to-back random normals
        f0 = n_fires;
        p0 = n_pops;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a = rand_norm(); b = rand_norm();
            bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
            exp_val = fp_add_model(a, b);
            step();
        end
        bus.in_valid = 1'b0;
        repeat (7) step();
        check("stream_fires", 32'(n_fires - f0), 32'd100);
        check("stream_pops", 32'(n_pops - p0), 32'd100);
        drain("stream_drain");

`ifdef ADD_STREAM_SPECIAL_EN
        // Special operands overridden by the wrapper
        bus.out_ready = 1'b1;
        issue(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000);
        issue(32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000);
        issue(32'h7FC0_0001, 32'h0000_0000, 32'h7FC0_0000);
        issue(32'h3F80_0000, 32'hFF80_0000, 32'hFF80_0000);
        drain("special_drain");
`endif

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
